checking_empty_level: RTL and testbench
=======================================

// Module: checking_empty_level
// PURPOSE
// Read-domain pointer, empty and fill-level stage of the asynchronous FIFO; the read-side partner of the write-pointer/full logic.
// Brings the Gray write pointer into rdclk through a 2-flop synchroniser.
// Advances the binary and Gray read pointers on accepted reads.
// Registers empty, almost_empty, fill level and a sticky underflow flag for the consumer and the dual-port RAM read port.
// PARAMETERS
// Addr       3  RAM address width; depth = 2**Addr, pointers are Addr+1 bits (extra wrap bit)
// AE_THRESH  2  almost_empty asserts when rd_level <= AE_THRESH (0..2**Addr)
// PORTS
// rdclk      in   1       read-domain clock, all state on rising edge
// rst        in   1       reset, asynchronous, active-high
// wrptr      in   Addr+1  Gray write pointer from write domain (asynchronous, 1 bit changes per step)
// rdreq      in   1       consumer read request
// rden       out  1       RAM read enable = rdreq & ~empty_reg (combinational)
// rdaddr     out  Addr+1  binary read pointer; RAM address = rdaddr[Addr-1:0]
// rdptr      out  Addr+1  Gray read pointer, to write-domain synchroniser
// empty_reg  out  1       registered empty flag
// almost_empty out 1      registered, rd_level <= AE_THRESH
// rd_level   out  Addr+1  registered words available, 0..2**Addr
// underflow  out  1       sticky: read requested while empty
// BEHAVIOUR
// - Reset (async, on rst rise, no clock needed): wq1=wq2=0, rdaddr=0, rdptr=0, empty_reg=1, almost_empty=1, rd_level=0, underflow=0.
// - Synchroniser: wq1<=wrptr, wq2<=wq1 each rdclk; only wq2 is used downstream; no other logic reads wrptr.
// - rdnext = (rdreq & ~empty_reg) ? rdaddr+1 : rdaddr, modulo 2**(Addr+1).
// - rdnext_gray = (rdnext>>1)^rdnext.
// - Each edge: rdaddr<=rdnext, rdptr<=rdnext_gray.
// - empty_reg <= (rdnext_gray == wq2): reflects the post-read pointer, so the final read sets empty on the same edge.
// - wbin = Gray-to-binary(wq2), combinational XOR prefix from MSB.
// - rd_level <= (wbin - rdnext) mod 2**(Addr+1); never exceeds 2**Addr for legal wrptr.
// - almost_empty <= (level_next <= AE_THRESH), using the same next-state value.
// - underflow <= underflow | (rdreq & empty_reg); cleared only by rst.
// - Read while empty: pointers hold, rden=0, level unchanged, underflow set.
// - Latency: a wrptr change is visible in empty_reg/rd_level on the 3rd rdclk edge after it settles (2 sync + 1 reg).
//   Empty is therefore conservative (pessimistic), never optimistic.
// - Wrap: pointers roll 2**(Addr+1)-1 -> 0 with no special case. Gray MSB toggles each lap; the level subtraction is modular.
// - Simultaneous read and wq2 change in one cycle: both terms enter level_next; net level = old + writes_seen - 1.
// - Reset mid-operation: everything returns to reset values asynchronously.
//   The write domain must be reset in the same event, otherwise the level is invalid until wrptr returns to 0.
// TESTING (Addr=3, AE_THRESH=2)
// 1 rst=1 with no clock -> rdaddr=0, rdptr=0, empty_reg=1, almost_empty=1, rd_level=0, underflow=0, rden=0.
// 2 wrptr 4'b0000->4'b0001 (one write) -> empty_reg=0, rd_level=1 on 3rd rdclk edge; almost_empty stays 1.
// 3 wrptr stepped in Gray to 4'b1100 (8 words) -> rd_level=8, almost_empty=0; rdreq held for 8 cycles ->
//   rdaddr counts 1..8, rdptr=4'b1100, empty_reg=1 on the 8th read edge, rd_level=0, rden low afterwards.
//   almost_empty=1 once rd_level<=2.
// 4 Second lap of 8 writes/8 reads -> rdaddr wraps 15->0, rdptr=4'b0000, rd_level tracks 8..0 correctly, no underflow.
// 5 rdreq=1 while empty_reg=1 -> rdaddr unchanged, rden=0, underflow=1.
//   underflow stays 1 after later valid reads, clears only on rst.
// 6 rst pulsed mid-drain at rd_level=5, between clock edges -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/checking_empty_level.sv
// Read-domain side of the asynchronous FIFO: write-pointer synchroniser, read pointers,
// and registered empty / almost_empty / fill level / sticky underflow flags.
module checking_empty_level #(
    parameter int Addr      = 3,
    parameter int AE_THRESH = 2
) (
    input  logic            rdclk,
    input  logic            rst,
    input  logic [Addr:0]   wrptr,
    input  logic            rdreq,
    output logic            rden,
    output logic [Addr:0]   rdaddr,
    output logic [Addr:0]   rdptr,
    output logic            empty_reg,
    output logic            almost_empty,
    output logic [Addr:0]   rd_level,
    output logic            underflow
);

    localparam logic [Addr:0] AeLimit = (Addr+1)'(AE_THRESH);
    localparam logic [Addr:0] One     = (Addr+1)'(1);

    logic [Addr:0] wq1;
    logic [Addr:0] wq2;
    logic [Addr:0] rdnext;
    logic [Addr:0] rdnext_gray;
    logic [Addr:0] wbin;
    logic [Addr:0] level_next;

    function automatic logic [Addr:0] bin2gray(input logic [Addr:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [Addr:0] gray2bin(input logic [Addr:0] g);
        logic [Addr:0] b;
        b = g;
        for (int i = Addr - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign rden        = rdreq & ~empty_reg;
    assign rdnext      = rden ? rdaddr + One : rdaddr;
    assign rdnext_gray = bin2gray(rdnext);
    assign wbin        = gray2bin(wq2);
    // Modular difference handles pointer wrap; the extra MSB keeps full distinct from empty.
    assign level_next  = wbin - rdnext;

    always_ff @(posedge rdclk or posedge rst) begin
        if (rst) begin
            wq1          <= '0;
            wq2          <= '0;
            rdaddr       <= '0;
            rdptr        <= '0;
            empty_reg    <= 1'b1;
            almost_empty <= 1'b1;
            rd_level     <= '0;
            underflow    <= 1'b0;
        end else begin
            // Two-flop synchroniser stage; only wq2 feeds the flag logic.
            wq1          <= wrptr;
            wq2          <= wq1;
            rdaddr       <= rdnext;
            rdptr        <= rdnext_gray;
            empty_reg    <= (rdnext_gray == wq2);
            rd_level     <= level_next;
            almost_empty <= (level_next <= AeLimit);
            underflow    <= underflow | (rdreq & empty_reg);
        end
    end

endmodule

// File: tb/tb_checking_empty_level.sv
// Directed bench for checking_empty_level: write/read counters drive a count-based model
// that is compared against every DUT output on each read clock.
module tb_checking_empty_level;

    logic       rdclk = 1'b0;
    logic       rst   = 1'b0;
    logic [3:0] wrptr = 4'b0000;
    logic       rdreq = 1'b0;
    logic       rden;
    logic [3:0] rdaddr;
    logic [3:0] rdptr;
    logic       empty_reg;
    logic       almost_empty;
    logic [3:0] rd_level;
    logic       underflow;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;

    // Model state: read count, two-deep delay of write count, derived flags.
    logic [3:0] m_rd    = 4'd0;
    logic [3:0] h1      = 4'd0;
    logic [3:0] h2      = 4'd0;
    logic [3:0] m_level = 4'd0;
    logic       m_empty = 1'b1;
    logic       m_ae    = 1'b1;
    logic       m_uf    = 1'b0;

    checking_empty_level #(.Addr(3), .AE_THRESH(2)) dut (
        .rdclk        (rdclk),
        .rst          (rst),
        .wrptr        (wrptr),
        .rdreq        (rdreq),
        .rden         (rden),
        .rdaddr       (rdaddr),
        .rdptr        (rdptr),
        .empty_reg    (empty_reg),
        .almost_empty (almost_empty),
        .rd_level     (rd_level),
        .underflow    (underflow)
    );

    initial begin
        #5;
        forever #5 rdclk = ~rdclk;
    end

    function automatic logic [3:0] gray4(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic write1();
        @(negedge rdclk);
        wr_cnt++;
        wrptr = gray4(wr_cnt[3:0]);
    endtask

    // Model and per-cycle comparison.
    initial begin
        logic [3:0] seen;
        forever begin
            @(posedge rdclk or posedge rst);
            if (rst) begin
                m_rd = 0; h1 = 0; h2 = 0; m_level = 0;
                m_empty = 1'b1; m_ae = 1'b1; m_uf = 1'b0;
            end else begin
                seen = h2;
                h2 = h1;
                h1 = wr_cnt[3:0];
                if (rdreq && m_empty) m_uf = 1'b1;
                if (rdreq && !m_empty) m_rd = m_rd + 4'd1;
                m_level = seen - m_rd;
                m_empty = (m_level == 4'd0);
                m_ae    = (m_level <= 4'd2);
                #1;
                if (!rst) begin
                    check("cyc_rdaddr", {28'd0, rdaddr}, {28'd0, m_rd});
                    check("cyc_rdptr", {28'd0, rdptr}, {28'd0, gray4(m_rd)});
                    check("cyc_empty", {31'd0, empty_reg}, {31'd0, m_empty});
                    check("cyc_almost_empty", {31'd0, almost_empty}, {31'd0, m_ae});
                    check("cyc_rd_level", {28'd0, rd_level}, {28'd0, m_level});
                    check("cyc_underflow", {31'd0, underflow}, {31'd0, m_uf});
                    check("cyc_rden", {31'd0, rden}, {31'd0, rdreq & ~m_empty});
                end
            end
        end
    end

    initial begin
        // Asynchronous reset before any clock edge.
        #1 rst = 1'b1;
        #1;
        check("rst_rdaddr", {28'd0, rdaddr}, 32'd0);
        check("rst_rdptr", {28'd0, rdptr}, 32'd0);
        check("rst_empty", {31'd0, empty_reg}, 32'd1);
        check("rst_almost_empty", {31'd0, almost_empty}, 32'd1);
        check("rst_rd_level", {28'd0, rd_level}, 32'd0);
        check("rst_underflow", {31'd0, underflow}, 32'd0);
        check("rst_rden", {31'd0, rden}, 32'd0);
        repeat (2) @(negedge rdclk);
        rst = 1'b0;

        // One write: visible on the third edge.
        write1();
        repeat (2) @(posedge rdclk);
        #1 check("w1_still_empty", {31'd0, empty_reg}, 32'd1);
        @(posedge rdclk);
        #1;
        check("w1_empty", {31'd0, empty_reg}, 32'd0);
        check("w1_level", {28'd0, rd_level}, 32'd1);
        check("w1_almost_empty", {31'd0, almost_empty}, 32'd1);

        // Fill to 8 words, then drain with rdreq held.
        repeat (7) write1();
        check("fill_wrptr", {28'd0, wrptr}, 32'd12);
        repeat (3) @(posedge rdclk);
        #1;
        check("fill_level", {28'd0, rd_level}, 32'd8);
        check("fill_almost_empty", {31'd0, almost_empty}, 32'd0);
        @(negedge rdclk);
        rdreq = 1'b1;
        repeat (5) @(posedge rdclk);
        #1;
        check("drain5_level", {28'd0, rd_level}, 32'd3);
        check("drain5_ae", {31'd0, almost_empty}, 32'd0);
        @(posedge rdclk);
        #1;
        check("drain6_level", {28'd0, rd_level}, 32'd2);
        check("drain6_ae", {31'd0, almost_empty}, 32'd1);
        repeat (2) @(posedge rdclk);
        #1;
        check("drain_rdaddr", {28'd0, rdaddr}, 32'd8);
        check("drain_rdptr", {28'd0, rdptr}, 32'd12);
        check("drain_empty", {31'd0, empty_reg}, 32'd1);
        check("drain_level", {28'd0, rd_level}, 32'd0);
        @(negedge rdclk);
        rdreq = 1'b0;
        #1 check("drain_rden_low", {31'd0, rden}, 32'd0);

        // Second lap with overlapping writes and reads; pointers wrap to 0.
        for (int i = 0; i < 12; i++) begin
            @(negedge rdclk);
            if (i < 8) begin
                wr_cnt++;
                wrptr = gray4(wr_cnt[3:0]);
            end
            rdreq = (i >= 3 && i <= 10);
        end
        repeat (3) @(posedge rdclk);
        #1;
        check("lap2_rdaddr", {28'd0, rdaddr}, 32'd0);
        check("lap2_rdptr", {28'd0, rdptr}, 32'd0);
        check("lap2_empty", {31'd0, empty_reg}, 32'd1);
        check("lap2_level", {28'd0, rd_level}, 32'd0);
        check("lap2_underflow", {31'd0, underflow}, 32'd0);

        // Read while empty sets sticky underflow.
        @(negedge rdclk);
        rdreq = 1'b1;
        #1 check("uf_rden", {31'd0, rden}, 32'd0);
        @(posedge rdclk);
        #1;
        check("uf_rdaddr", {28'd0, rdaddr}, 32'd0);
        check("uf_set", {31'd0, underflow}, 32'd1);
        @(negedge rdclk);
        rdreq = 1'b0;
        repeat (3) write1();
        repeat (3) @(posedge rdclk);
        @(negedge rdclk);
        rdreq = 1'b1;
        @(posedge rdclk);
        #1;
        check("uf_sticky", {31'd0, underflow}, 32'd1);
        check("uf_read_ok", {28'd0, rdaddr}, 32'd1);
        @(negedge rdclk);
        rdreq = 1'b0;

        // Reset between edges while draining at level 5.
        repeat (3) write1();
        repeat (3) @(posedge rdclk);
        #1 check("pre_rst_level", {28'd0, rd_level}, 32'd5);
        @(negedge rdclk);
        rdreq = 1'b1;
        #1 check("pre_rst_rden", {31'd0, rden}, 32'd1);
        #1;
        rst = 1'b1;
        wr_cnt = 0;
        wrptr = 4'b0000;
        #1;
        check("mid_rst_rdaddr", {28'd0, rdaddr}, 32'd0);
        check("mid_rst_rdptr", {28'd0, rdptr}, 32'd0);
        check("mid_rst_empty", {31'd0, empty_reg}, 32'd1);
        check("mid_rst_almost_empty", {31'd0, almost_empty}, 32'd1);
        check("mid_rst_level", {28'd0, rd_level}, 32'd0);
        check("mid_rst_underflow", {31'd0, underflow}, 32'd0);
        check("mid_rst_rden", {31'd0, rden}, 32'd0);
        rst = 1'b0;
        rdreq = 1'b0;
        repeat (4) @(posedge rdclk);
        #2;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
